spcpu_byte_mem_bridge: RTL and testbench

Bus bridge directly downstream of the spcpu core's data/instruction bus.
- Accepts one 8-bit or 16-bit read/write request at a time through a valid/ready handshake.
- Sequences each request into one or two byte-wide accesses on an external SRAM with programmable wait states.
- Returns the assembled read data, or a write completion, as a one-cycle response pulse.
- Replaces the ideal zero-wait test memory so the core can run against realistic byte-wide storage.

---
 rtl/spcpu_byte_mem_bridge.sv | 194 +++++++++++++++++++
 tb/tb_spcpu_byte_mem_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spcpu_byte_mem_bridge.sv
// Byte-wide SRAM bridge for the spcpu bus: splits 8/16-bit requests into
// one or two byte phases with programmable wait states and a one-cycle response.
module spcpu_byte_mem_bridge #(
  parameter int ADDR_WIDTH       = 16,
  parameter int SRAM_WAIT_CYCLES = 1,
  parameter bit BIG_ENDIAN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic                  req_sz,
  input  logic [15:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_wdata,
  input  logic [7:0]            sram_rdata
);

  localparam logic [3:0] WAIT_LD = 4'(SRAM_WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_next_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic                  r_sz;
  logic [15:0]           r_wdata;
  logic [7:0]            r_byte0;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [15:0]           r_rsp_rdata;
  logic                  r_sram_en;
  logic                  r_sram_we;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [7:0]            r_sram_wdata;

  logic                  w_accept;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_cap_addr;
  logic                  w_cap_we;
  logic                  w_cap_sz;
  logic [15:0]           w_cap_wdata;
  logic [7:0]            w_first_byte;
  logic [7:0]            w_second_byte;
  logic                  w_sram_en_d;
  logic                  w_sram_we_d;
  logic [ADDR_WIDTH-1:0] w_sram_addr_d;
  logic [7:0]            w_sram_wdata_d;
  logic [15:0]           w_next_rdata;

  assign w_accept = req_valid && r_req_ready;
  assign w_last   = (r_wait_cnt == 4'd0);

  // Outputs are registered from next-state, so the request being accepted is
  // seen through the live inputs until it lands in the capture registers.
  assign w_cap_addr  = w_accept ? req_addr  : r_addr;
  assign w_cap_we    = w_accept ? req_we    : r_we;
  assign w_cap_sz    = w_accept ? req_sz    : r_sz;
  assign w_cap_wdata = w_accept ? req_wdata : r_wdata;

  assign w_first_byte  = (BIG_ENDIAN && w_cap_sz) ? w_cap_wdata[15:8] : w_cap_wdata[7:0];
  assign w_second_byte = BIG_ENDIAN ? w_cap_wdata[7:0] : w_cap_wdata[15:8];

  // Next-state and wait-counter sequencing
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state    = BYTE0;
          w_next_wait_cnt = WAIT_LD;
        end else begin
          w_next_state    = IDLE;
        end
      end
      BYTE0: begin
        if (w_last && r_sz) begin
          w_next_state    = BYTE1;
          w_next_wait_cnt = WAIT_LD;
        end else if (w_last) begin
          w_next_state    = RESP;
        end else begin
          w_next_wait_cnt = r_wait_cnt - 4'd1;
        end
      end
      BYTE1: begin
        if (w_last) begin
          w_next_state    = RESP;
        end else begin
          w_next_wait_cnt = r_wait_cnt - 4'd1;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // SRAM strobe/address/data for the cycle after the edge
  always_comb begin
    w_sram_en_d    = (w_next_state == BYTE0) || (w_next_state == BYTE1);
    w_sram_we_d    = w_sram_en_d && w_cap_we;
    w_sram_addr_d  = {ADDR_WIDTH{1'b0}};
    w_sram_wdata_d = 8'h00;
    if (w_next_state == BYTE1) begin
      w_sram_addr_d  = w_cap_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      w_sram_wdata_d = w_second_byte;
    end else if (w_next_state == BYTE0) begin
      w_sram_addr_d  = w_cap_addr;
      w_sram_wdata_d = w_first_byte;
    end else begin
      w_sram_addr_d  = {ADDR_WIDTH{1'b0}};
      w_sram_wdata_d = 8'h00;
    end
  end

  // Response data assembly; the final byte is taken straight off sram_rdata
  always_comb begin
    w_next_rdata = r_rsp_rdata;
    if (w_next_state == RESP) begin
      if (r_we) begin
        w_next_rdata = 16'h0000;
      end else if (r_sz) begin
        w_next_rdata = BIG_ENDIAN ? {r_byte0, sram_rdata} : {sram_rdata, r_byte0};
      end else begin
        w_next_rdata = {8'h00, sram_rdata};
      end
    end else begin
      w_next_rdata = r_rsp_rdata;
    end
  end

  // State, capture and registered-output update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 4'd0;
      r_addr       <= {ADDR_WIDTH{1'b0}};
      r_we         <= 1'b0;
      r_sz         <= 1'b0;
      r_wdata      <= 16'h0000;
      r_byte0      <= 8'h00;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= 16'h0000;
      r_sram_en    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= {ADDR_WIDTH{1'b0}};
      r_sram_wdata <= 8'h00;
    end else begin
      r_state      <= w_next_state;
      r_wait_cnt   <= w_next_wait_cnt;
      r_req_ready  <= (w_next_state == IDLE);
      r_rsp_valid  <= (w_next_state == RESP);
      r_rsp_rdata  <= w_next_rdata;
      r_sram_en    <= w_sram_en_d;
      r_sram_we    <= w_sram_we_d;
      r_sram_addr  <= w_sram_addr_d;
      r_sram_wdata <= w_sram_wdata_d;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_sz    <= req_sz;
        r_wdata <= req_wdata;
      end
      if ((r_state == BYTE0) && w_last && !r_we) begin
        r_byte0 <= sram_rdata;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign sram_en    = r_sram_en;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_spcpu_byte_mem_bridge.sv
// Bench for spcpu_byte_mem_bridge: two instances (W=1/big-endian, W=0/little-endian)
// against behavioural SRAMs, with per-instance scoreboards and a reference memory.
module tb_spcpu_byte_mem_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid;
  logic        req_we;
  logic        req_sz;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        sel;

  logic        rdy_a, rv_a, en_a, we_a;
  logic [15:0] rd_a, addr_a;
  logic [7:0]  wd_a, srd_a;
  logic        rdy_b, rv_b, en_b, we_b;
  logic [15:0] rd_b, addr_b;
  logic [7:0]  wd_b, srd_b;

  logic [7:0] mem_a [0:65535] = '{default: 8'h00};
  logic [7:0] mem_b [0:65535] = '{default: 8'h00};
  logic [7:0] ref_a [0:65535] = '{default: 8'h00};
  logic [7:0] ref_b [0:65535] = '{default: 8'h00};

  assign srd_a = mem_a[addr_a];
  assign srd_b = mem_b[addr_b];

  spcpu_byte_mem_bridge #(.ADDR_WIDTH(16), .SRAM_WAIT_CYCLES(1), .BIG_ENDIAN(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(rdy_a), .req_addr(req_addr),
    .req_we(req_we), .req_sz(req_sz), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_rdata(rd_a),
    .sram_en(en_a), .sram_we(we_a), .sram_addr(addr_a), .sram_wdata(wd_a), .sram_rdata(srd_a)
  );

  spcpu_byte_mem_bridge #(.ADDR_WIDTH(16), .SRAM_WAIT_CYCLES(0), .BIG_ENDIAN(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(rdy_b), .req_addr(req_addr),
    .req_we(req_we), .req_sz(req_sz), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_rdata(rd_b),
    .sram_en(en_b), .sram_we(we_b), .sram_addr(addr_b), .sram_wdata(wd_b), .sram_rdata(srd_b)
  );

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
  } acc_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  acc_t log_q[$];
  int   cyc = 0;
  int   last_acc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // SRAM write port and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en_a && we_a) mem_a[addr_a] <= wd_a;
    if (en_b && we_b) mem_b[addr_b] <= wd_b;
  end

  // Response scoreboard, strobe legality and access log
  always @(negedge clk) begin
    exp_t e;
    chk("sram_excl", {30'd0,
        (en_a && (rdy_a || rv_a)) || (we_a && !en_a),
        (en_b && (rdy_b || rv_b)) || (we_b && !en_b)}, 32'd0);
    if (rv_a) begin
      if (sb_a.size() == 0) chk("rsp_a_unexpected", 32'd1, 32'd0);
      else begin
        e = sb_a.pop_front();
        chk("rsp_a_data", {16'd0, rd_a}, {16'd0, e.data});
        chk("rsp_a_lat", cyc - e.acc, e.lat);
      end
    end
    if (rv_b) begin
      if (sb_b.size() == 0) chk("rsp_b_unexpected", 32'd1, 32'd0);
      else begin
        e = sb_b.pop_front();
        chk("rsp_b_data", {16'd0, rd_b}, {16'd0, e.data});
        chk("rsp_b_lat", cyc - e.acc, e.lat);
      end
    end
    if (sel ? en_b : en_a) log_q.push_back('{we: (sel ? we_b : we_a),
                                           addr: (sel ? addr_b : addr_a),
                                           wd: (sel ? wd_b : wd_a)});
  end

  task automatic send(input logic s, input logic [15:0] a, input logic w,
                      input logic z, input logic [15:0] d);
    int          n;
    bit          ok;
    bit          be;
    logic [15:0] a1;
    logic [7:0]  b0, b1;
    exp_t        e;
    n  = 0;
    ok = 1'b0;
    be = (s == 1'b0);
    a1 = a + 16'd1;
    sel = s; req_addr = a; req_we = w; req_sz = z; req_wdata = d; req_valid = 1'b1;
    while (n < 40 && !ok) begin
      @(negedge clk);
      if (s ? rdy_b : rdy_a) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc;
    e.lat = (z ? 2 : 1) * ((s ? 0 : 1) + 1) + 1;
    b0 = s ? ref_b[a] : ref_a[a];
    b1 = s ? ref_b[a1] : ref_a[a1];
    if (w) e.data = 16'h0000;
    else if (z) e.data = be ? {b0, b1} : {b1, b0};
    else e.data = {8'h00, b0};
    if (s) sb_b.push_back(e);
    else sb_a.push_back(e);
    if (w && z) begin
      if (s) begin ref_b[a] = d[7:0]; ref_b[a1] = d[15:8]; end
      else begin ref_a[a] = d[15:8]; ref_a[a1] = d[7:0]; end
    end else if (w) begin
      if (s) ref_b[a] = d[7:0];
      else ref_a[a] = d[7:0];
    end
    last_acc = e.acc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    req_we    = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 100 && (sb_a.size() + sb_b.size()) != 0) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_a.size() + sb_b.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   acc1;
    int   n;
    bit   hit;
    logic s;
    logic [15:0] a;
    reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sz = 1'b0;
    req_addr = 16'h0000; req_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, rdy_a}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rv_a}, 32'd0);
    chk("rst_rdata", {16'd0, rd_a}, 32'd0);
    chk("rst_en_we", {30'd0, en_a, we_a}, 32'd0);
    chk("rst_addr_wd", {8'd0, addr_a, wd_a}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", {30'd0, rdy_a, rdy_b}, 32'd3);
    chk("idle_en", {30'd0, en_a, en_b}, 32'd0);
    @(posedge clk); #1;

    send(1'b0, 16'h0010, 1'b1, 1'b0, 16'h00AB);
    send(1'b0, 16'h0011, 1'b1, 1'b0, 16'h00CD);
    send(1'b0, 16'h0021, 1'b1, 1'b0, 16'h005A);
    drain();

    log_q.delete();
    send(1'b0, 16'h0010, 1'b0, 1'b1, 16'h0000);
    drain();
    chk("rd16_rdata", {16'd0, rd_a}, 32'h0000ABCD);
    chk("rd16_phases", log_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        chk("rd16_addr", {16'd0, log_q[i].addr}, (i < 2) ? 32'h10 : 32'h11);
        chk("rd16_we", {31'd0, log_q[i].we}, 32'd0);
      end
    end

    log_q.delete();
    send(1'b0, 16'h0020, 1'b1, 1'b0, 16'h1234);
    drain();
    chk("wr8_phases", log_q.size(), 32'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < log_q.size()) begin
        chk("wr8_access", {7'd0, log_q[i].we, log_q[i].addr, log_q[i].wd}, {7'd0, 1'b1, 16'h0020, 8'h34});
      end
    end
    chk("wr8_mem", {24'd0, mem_a[16'h0020]}, 32'h34);
    chk("wr8_neighbour", {24'd0, mem_a[16'h0021]}, 32'h5A);
    chk("wr8_rdata", {16'd0, rd_a}, 32'd0);

    send(1'b0, 16'hFFFF, 1'b1, 1'b1, 16'hBEEF);
    drain();
    chk("wrap_hi", {24'd0, mem_a[16'hFFFF]}, 32'hBE);
    chk("wrap_lo", {24'd0, mem_a[16'h0000]}, 32'hEF);
    send(1'b0, 16'hFFFF, 1'b0, 1'b1, 16'h0000);
    drain();
    chk("wrap_read", {16'd0, rd_a}, 32'h0000BEEF);

    send(1'b1, 16'h0005, 1'b1, 1'b0, 16'hAA7F);
    drain();
    chk("b_wr8_mem", {16'd0, mem_b[16'h0005], mem_b[16'h0006]}, 32'h7F00);
    send(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000);
    acc1 = last_acc;
    send(1'b1, 16'h0005, 1'b0, 1'b1, 16'h0000);
    chk("b_b2b_gap", last_acc - acc1, 32'd3);
    drain();
    chk("b_rd16_le", {16'd0, rd_b}, 32'h0000007F);

    send(1'b0, 16'h0200, 1'b1, 1'b1, 16'h1357);
    n = 0; hit = 1'b0;
    while (n < 10 && !hit) begin
      @(negedge clk);
      if (en_a && addr_a == 16'h0201) hit = 1'b1;
      else n++;
    end
    chk("abort_reach_byte1", {31'd0, hit}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_en_we", {30'd0, en_a, we_a}, 32'd0);
    sb_a.delete();
    repeat (2) @(negedge clk);
    chk("abort_ready_in_rst", {31'd0, rdy_a}, 32'd1);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_ready_after", {31'd0, rdy_a}, 32'd1);
    chk("abort_no_rsp", sb_a.size(), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'h0100 + 16'($urandom_range(0, 15));
      send(s, a, 1'($urandom), 1'($urandom), 16'($urandom));
    end
    drain();
    repeat (4) @(negedge clk);
    chk("final_queues", sb_a.size() + sb_b.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
